// File: rtl/adder_if.sv
// Operand/result bundle for the registered CLA adder.
// The master drives the operands; the slave (the adder) returns the registered result and flags.
interface adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output a,
        output b,
        input  sum,
        input  carry_out,
        input  overflow,
        input  zero
    );

    modport slave (
        input  a,
        input  b,
        output sum,
        output carry_out,
        output overflow,
        output zero
    );
endinterface

// File: rtl/adder.sv
// Single-cycle registered adder built from 4-bit carry-lookahead groups with a flattened
// group-level lookahead; sum, carry, signed overflow and zero are all registered together.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    adder_if.slave bus
);
    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic [3:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                             input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [PW-1:0]    w_g;
    logic [PW-1:0]    w_p;
    logic [PW-1:0]    w_c;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_cg;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum_p1;
    logic             r_cout_p1;
    logic             r_ovf_p1;
    logic             r_zero_p1;

    // Stage p0: combinational CLA on the live operands
    always_comb begin
        logic w_term;
        logic w_prod;
        // Padding bits above WIDTH propagate without generating, so a truncated top
        // group passes its real carry straight through to the group carry-out.
        w_g = '0;
        w_p = '1;
        w_g[WIDTH-1:0] = bus.a & bus.b;
        w_p[WIDTH-1:0] = bus.a ^ bus.b;

        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < NG; k++) begin
            w_gg[k] = grp_gen(w_g[4*k +: 4], w_p[4*k +: 4]);
            w_gp[k] = &w_p[4*k +: 4];
        end

        // Each group carry is a flat OR of generate terms gated by higher propagates.
        w_cg = '0;
        for (int k = 0; k < NG; k++) begin
            w_term = 1'b0;
            for (int j = 0; j <= k; j++) begin
                w_prod = w_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    w_prod = w_prod & w_gp[m];
                end
                w_term = w_term | w_prod;
            end
            w_cg[k+1] = w_term;
        end

        w_c = '0;
        for (int k = 0; k < NG; k++) begin
            w_c[4*k +: 4] = grp_carry(w_g[4*k +: 4], w_p[4*k +: 4], w_cg[k]);
        end

        w_sum = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];
        w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
    end

    // Stage p1: result and flags captured together from one operand pair
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_p1  <= '0;
            r_cout_p1 <= 1'b0;
            r_ovf_p1  <= 1'b0;
            r_zero_p1 <= 1'b1;
        end else begin
            r_sum_p1  <= w_sum;
            r_cout_p1 <= w_cg[NG];
            r_ovf_p1  <= w_ovf;
            r_zero_p1 <= ~|w_sum;
        end
    end

    assign bus.sum       = r_sum_p1;
    assign bus.carry_out = r_cout_p1;
    assign bus.overflow  = r_ovf_p1;
    assign bus.zero      = r_zero_p1;
endmodule

// File: tb/tb_adder.sv
// Bench for the registered adder: directed vectors on a 32-bit instance, then random
// operands with random reset pulses on 32-, 8- and 13-bit instances against an arithmetic model.
module tb_adder;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    adder_if #(.WIDTH(32)) if32 ();
    adder_if #(.WIDTH(8))  if8 ();
    adder_if #(.WIDTH(13)) if13 ();

    adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    adder #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13.slave));

    // Expected {sum(64), carry, overflow, zero} from plain wide arithmetic.
    function automatic logic [66:0] ref_out(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic r);
        logic [64:0] mask;
        logic [64:0] full;
        logic [64:0] s;
        logic        co;
        logic        ov;
        if (r) return {64'd0, 1'b0, 1'b0, 1'b1};
        mask = (65'd1 << w) - 65'd1;
        full = ({1'b0, a} & mask) + ({1'b0, b} & mask);
        s    = full & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {s[63:0], co, ov, (s == 65'd0)};
    endfunction

    task automatic drive(input logic [63:0] a, input logic [63:0] b);
        if32.a = a[31:0];
        if32.b = b[31:0];
        if8.a  = a[7:0];
        if8.b  = b[7:0];
        if13.a = a[12:0];
        if13.b = b[12:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(64'h12345678, 64'h87654321);
        tick();
        tick();
        checks++;
        if (if32.sum !== 32'h0) begin
            errors++; $display("FAIL reset_sum got=%h exp=%h", if32.sum, 32'h0);
        end
        checks++;
        if ({if32.carry_out, if32.overflow, if32.zero} !== 3'b001) begin
            errors++; $display("FAIL reset_flags got=%b exp=%b",
                               {if32.carry_out, if32.overflow, if32.zero}, 3'b001);
        end
        checks++;
        if ({if8.sum, if8.zero, if13.sum, if13.zero} !== {8'h0, 1'b1, 13'h0, 1'b1}) begin
            errors++; $display("FAIL reset_narrow got=%h/%b %h/%b exp=00/1 0000/1",
                               if8.sum, if8.zero, if13.sum, if13.zero);
        end
    endtask

    task automatic test_basic();
        rst = 1'b0;
        drive(64'h1, 64'h1);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow, if32.zero} !== {32'h2, 3'b000}) begin
            errors++; $display("FAIL basic_1p1 got=%h %b%b%b exp=00000002 000", if32.sum,
                               if32.carry_out, if32.overflow, if32.zero);
        end
    endtask

    task automatic test_hold();
        drive(64'h5, 64'h5);
        #3;
        checks++;
        if ({if32.sum, if32.zero} !== {32'h2, 1'b0}) begin
            errors++; $display("FAIL hold_between_edges got=%h/%b exp=00000002/0",
                               if32.sum, if32.zero);
        end
        tick();
        checks++;
        if (if32.sum !== 32'hA) begin
            errors++; $display("FAIL hold_next_edge got=%h exp=0000000a", if32.sum);
        end
    endtask

    task automatic test_wrap();
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow, if32.zero} !== {32'h0, 3'b101}) begin
            errors++; $display("FAIL wrap32 got=%h %b%b%b exp=00000000 101", if32.sum,
                               if32.carry_out, if32.overflow, if32.zero);
        end
        checks++;
        if ({if8.sum, if8.carry_out, if8.overflow, if8.zero} !== {8'h0, 3'b101}) begin
            errors++; $display("FAIL wrap8 got=%h %b%b%b exp=00 101", if8.sum,
                               if8.carry_out, if8.overflow, if8.zero);
        end
        checks++;
        if ({if13.sum, if13.carry_out, if13.overflow, if13.zero} !== {13'h0, 3'b101}) begin
            errors++; $display("FAIL wrap13 got=%h %b%b%b exp=0000 101", if13.sum,
                               if13.carry_out, if13.overflow, if13.zero);
        end
    endtask

    task automatic test_patterns();
        drive(64'h12345678, 64'h87654321);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow, if32.zero} !== {32'h99999999, 3'b000}) begin
            errors++; $display("FAIL pat_9999 got=%h %b%b%b exp=99999999 000", if32.sum,
                               if32.carry_out, if32.overflow, if32.zero);
        end
        drive(64'h0000FFFF, 64'hFFFF0000);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.zero} !== {32'hFFFFFFFF, 2'b00}) begin
            errors++; $display("FAIL pat_ffff got=%h %b%b exp=ffffffff 00", if32.sum,
                               if32.carry_out, if32.zero);
        end
        drive(64'hABCDEF12, 64'h12345678);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow} !== {32'hBE02458A, 2'b00}) begin
            errors++; $display("FAIL pat_be02 got=%h %b%b exp=be02458a 00", if32.sum,
                               if32.carry_out, if32.overflow);
        end
        drive(64'h7FFFFFFF, 64'h1);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow, if32.zero} !== {32'h80000000, 3'b010}) begin
            errors++; $display("FAIL pos_overflow got=%h %b%b%b exp=80000000 010", if32.sum,
                               if32.carry_out, if32.overflow, if32.zero);
        end
        drive(64'h80000000, 64'h80000000);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow, if32.zero} !== {32'h0, 3'b111}) begin
            errors++; $display("FAIL neg_overflow got=%h %b%b%b exp=00000000 111", if32.sum,
                               if32.carry_out, if32.overflow, if32.zero);
        end
    endtask

    task automatic test_mid_reset();
        drive(64'h3, 64'h4);
        tick();
        rst = 1'b1;
        drive(64'h9, 64'h9);
        tick();
        checks++;
        if ({if32.sum, if32.carry_out, if32.overflow, if32.zero} !== {32'h0, 3'b001}) begin
            errors++; $display("FAIL mid_reset got=%h %b%b%b exp=00000000 001", if32.sum,
                               if32.carry_out, if32.overflow, if32.zero);
        end
        rst = 1'b0;
        drive(64'd10, 64'd20);
        tick();
        checks++;
        if ({if32.sum, if32.zero} !== {32'd30, 1'b0}) begin
            errors++; $display("FAIL after_reset got=%h/%b exp=0000001e/0", if32.sum, if32.zero);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic        r;
        logic [66:0] exp;
        for (int i = 0; i < 10000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            // Bias some operands toward edge values to exercise long carry chains.
            if ($urandom_range(0, 7) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = -a;
            r = ($urandom_range(0, 19) == 0);
            rst = r;
            drive(a, b);
            tick();
            exp = ref_out(32, a, b, r);
            checks++;
            if ({32'd0, if32.sum, if32.carry_out, if32.overflow, if32.zero} !== exp) begin
                errors++; $display("FAIL rand32 cyc=%0d got=%h exp=%h", i,
                                   {32'd0, if32.sum, if32.carry_out, if32.overflow, if32.zero}, exp);
            end
            exp = ref_out(8, a, b, r);
            checks++;
            if ({56'd0, if8.sum, if8.carry_out, if8.overflow, if8.zero} !== exp) begin
                errors++; $display("FAIL rand8 cyc=%0d got=%h exp=%h", i,
                                   {56'd0, if8.sum, if8.carry_out, if8.overflow, if8.zero}, exp);
            end
            exp = ref_out(13, a, b, r);
            checks++;
            if ({51'd0, if13.sum, if13.carry_out, if13.overflow, if13.zero} !== exp) begin
                errors++; $display("FAIL rand13 cyc=%0d got=%h exp=%h", i,
                                   {51'd0, if13.sum, if13.carry_out, if13.overflow, if13.zero}, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(64'h0, 64'h0);
        test_reset();
        test_basic();
        test_hold();
        test_wrap();
        test_patterns();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
